seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the stopwatch 7-segment multiplexer.
- Samples the multiplexed active-low anode/segment lines and decodes each glyph back to a 4-bit digit.
- Reassembles the four digit positions into one coherent frame and flags protocol and glyph errors.
- Used as an on-chip self-check monitor and as the bench-side scoreboard front end for the display path.

---
 rtl/seg_scan_decoder.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// ============================================================================
// seg_scan_decoder
// ----------------------------------------------------------------------------
// This block is the receive side of the stopwatch 7-segment multiplexer. It
// samples the active-low anode and segment lines and decodes each glyph back
// to a 4-bit digit. It collects all four digit positions into a shadow frame
// and presents that frame on the outputs as one coherent update.
//
// Optional feature, selected by the macro SEG_SCAN_TIMEOUT_EN:
//   When the macro is defined, an idle counter discards a partly collected
//   frame after TIMEOUT_CYCLES cycles with no capture, and raises `stale`.
//   When the macro is not defined, there is no counter and `stale` is tied 0.
//
// Parameters
//   SETTLE_CYCLES   identical registered samples needed before capture (1..15)
//   TIMEOUT_CYCLES  idle cycles before the frame is declared stale
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   anode[3:0]     in   active-low digit enables, bit0 = seconds units
//   segments[6:0]  in   active-low segments {g,f,e,d,c,b,a}
//   minutes_tens   out  decoded digit, position 3
//   minutes_units  out  decoded digit, position 2
//   seconds_tens   out  decoded digit, position 1
//   seconds_units  out  decoded digit, position 0
//   frame_valid    out  1-cycle pulse when all four digits update together
//   glyph_error    out  1-cycle pulse when an unrecognised glyph is captured
//   anode_error    out  1-cycle pulse when a qualified sample has >1 anode low
//   stale          out  level, frame timed out (optional feature only)
//
// Handshake: this block has no valid/ready flow control. It always accepts the
// display lines. Every output is registered, and frame_valid marks the single
// cycle in which the four digit outputs carry a newly completed frame.
// ============================================================================
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] anode,
    input  logic [6:0] segments,
    output logic [3:0] minutes_tens,
    output logic [3:0] minutes_units,
    output logic [3:0] seconds_tens,
    output logic [3:0] seconds_units,
    output logic       frame_valid,
    output logic       glyph_error,
    output logic       anode_error,
    output logic       stale
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE_CYCLES);

    // There is a single collecting state. A frame completes and restarts on
    // the same edge, so no separate "present" state is needed.
    typedef enum logic [0:0] {
        COLLECT = 1'b0
    } state_e;

    // ------------------------------------------------------------------------
    // Input stage and stability tracking
    // ------------------------------------------------------------------------
    logic [3:0] r_anode_q;
    logic [6:0] r_seg_q;
    logic [3:0] p_anode_q;   // value of r_anode_q one cycle earlier
    logic [6:0] p_seg_q;     // value of r_seg_q one cycle earlier
    logic [3:0] stab_cnt_q;
    logic [3:0] stab_cnt_d;
    logic       qualify;

    always_comb begin
        stab_cnt_d = 4'd1;
        if ({r_anode_q, r_seg_q} == {p_anode_q, p_seg_q}) begin
            stab_cnt_d = (stab_cnt_q == 4'd15) ? 4'd15 : stab_cnt_q + 4'd1;
        end
    end

    // The count equals SETTLE_CNT on exactly one cycle of a stable run. That
    // gives one qualification per run. Once saturated at 15 it never matches
    // again unless SETTLE_CYCLES is 15.
    assign qualify = (stab_cnt_d == SETTLE_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_anode_q  <= 4'b1111;
            r_seg_q    <= 7'b1111111;
            p_anode_q  <= 4'b1111;
            p_seg_q    <= 7'b1111111;
            stab_cnt_q <= 4'd0;
        end else begin
            r_anode_q  <= anode;
            r_seg_q    <= segments;
            p_anode_q  <= r_anode_q;
            p_seg_q    <= r_seg_q;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Anode classification
    // ------------------------------------------------------------------------
    logic [1:0] pos;
    logic       one_hot;
    logic       multi_low;
    logic [3:0] low_bits;

    assign low_bits  = ~r_anode_q;
    // Clearing the lowest set bit leaves a nonzero value only when two or
    // more anodes are driven low.
    assign multi_low = ((low_bits & (low_bits - 4'd1)) != 4'd0);

    always_comb begin
        pos     = 2'd0;
        one_hot = 1'b0;
        case (r_anode_q)
            4'b1110: begin pos = 2'd0; one_hot = 1'b1; end
            4'b1101: begin pos = 2'd1; one_hot = 1'b1; end
            4'b1011: begin pos = 2'd2; one_hot = 1'b1; end
            4'b0111: begin pos = 2'd3; one_hot = 1'b1; end
            default: begin pos = 2'd0; one_hot = 1'b0; end
        endcase
    end

    // ------------------------------------------------------------------------
    // Glyph decode (active-low segments)
    // ------------------------------------------------------------------------
    logic [3:0] digit;
    logic       glyph_bad;

    always_comb begin
        digit     = 4'hF;
        glyph_bad = 1'b0;
        case (r_seg_q)
            7'b1000000: digit = 4'd0;
            7'b1111001: digit = 4'd1;
            7'b0100100: digit = 4'd2;
            7'b0110000: digit = 4'd3;
            7'b0011001: digit = 4'd4;
            7'b0010010: digit = 4'd5;
            7'b0000010: digit = 4'd6;
            7'b1111000: digit = 4'd7;
            7'b0000000: digit = 4'd8;
            7'b0010000: digit = 4'd9;
            7'b1111111: digit = 4'hA;   // a blank digit is legal, not an error
            default: begin
                digit     = 4'hF;
                glyph_bad = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Capture decisions
    // ------------------------------------------------------------------------
    logic       capture;
    logic       anode_err_d;
    logic [3:0] mask_q;
    logic [3:0] mask_d;
    logic       frame_done;
    logic [3:0] shadow_q [4];
    logic [3:0] frame_digits [4];
    logic       timeout_hit;

    assign capture     = qualify & one_hot;
    assign anode_err_d = qualify & multi_low;
    assign mask_d      = mask_q | (4'b0001 << pos);
    assign frame_done  = capture & (mask_d == 4'b1111);

    // The published frame includes the digit captured on this edge, because
    // the shadow slot for it is only written on the same edge.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            frame_digits[i] = (pos == 2'(i)) ? digit : shadow_q[i];
        end
    end

    // ------------------------------------------------------------------------
    // Optional stale-frame monitor
    // ------------------------------------------------------------------------
`ifdef SEG_SCAN_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT_CYCLES);

    logic [15:0] idle_q;
    logic        stale_q;

    // The counter keeps running past the threshold, which makes the timeout
    // fire only once per idle stretch.
    assign timeout_hit = ~capture & ((idle_q + 16'd1) == TIMEOUT_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_q  <= 16'd0;
            stale_q <= 1'b0;
        end else begin
            if (capture) begin
                idle_q <= 16'd0;
            end else if (idle_q != 16'hFFFF) begin
                idle_q <= idle_q + 16'd1;
            end

            if (frame_done) begin
                stale_q <= 1'b0;
            end else if (timeout_hit) begin
                stale_q <= 1'b1;
            end
        end
    end

    assign stale = stale_q;
`else
    // The timeout length is not needed when the stale monitor is compiled
    // out. It is still referenced here so that the parameter list stays the
    // same in both builds.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^16'(TIMEOUT_CYCLES);

    assign timeout_hit = 1'b0;
    assign stale       = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Frame assembly FSM: every output is registered here
    // ------------------------------------------------------------------------
    state_e     state_q;
    logic [3:0] mt_q, mu_q, st_q, su_q;
    logic       frame_valid_q;
    logic       glyph_error_q;
    logic       anode_error_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= COLLECT;
            mask_q        <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= 4'd0;
            end
            mt_q          <= 4'd0;
            mu_q          <= 4'd0;
            st_q          <= 4'd0;
            su_q          <= 4'd0;
            frame_valid_q <= 1'b0;
            glyph_error_q <= 1'b0;
            anode_error_q <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            glyph_error_q <= capture & glyph_bad;
            anode_error_q <= anode_err_d;

            case (state_q)
                COLLECT: begin
                    if (capture) begin
                        // A repeated position simply overwrites its slot.
                        shadow_q[pos] <= digit;
                        if (frame_done) begin
                            su_q          <= frame_digits[0];
                            st_q          <= frame_digits[1];
                            mu_q          <= frame_digits[2];
                            mt_q          <= frame_digits[3];
                            frame_valid_q <= 1'b1;
                            mask_q        <= 4'b0000;
                        end else begin
                            mask_q <= mask_d;
                        end
                    end else if (timeout_hit) begin
                        // A stale partial frame is dropped. The digit outputs
                        // keep the last complete frame.
                        mask_q <= 4'b0000;
                    end
                    state_q <= COLLECT;
                end
                default: begin
                    state_q <= COLLECT;
                    mask_q  <= 4'b0000;
                end
            endcase
        end
    end

    assign minutes_tens  = mt_q;
    assign minutes_units = mu_q;
    assign seconds_tens  = st_q;
    assign seconds_units = su_q;
    assign frame_valid   = frame_valid_q;
    assign glyph_error   = glyph_error_q;
    assign anode_error   = anode_error_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// ============================================================================
// tb_seg_scan_decoder
// ----------------------------------------------------------------------------
// Three decoder instances share one reset:
//   u_dut1  SETTLE_CYCLES=1              main function, errors, reset
//   u_dut3  SETTLE_CYCLES=3              settle qualification
//   u_dutt  SETTLE_CYCLES=1, TIMEOUT=16  stale monitor (SEG_SCAN_TIMEOUT_EN)
// Each instance has its own inputs. Expected frames are queued when a scan is
// driven. A monitor for each instance pops and compares them on frame_valid.
// Inputs change 1 time unit after each rising edge. Monitors sample on the
// falling edge.
// ============================================================================
module tb_seg_scan_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] an1, an3, ant;
    logic [6:0] sg1, sg3, sgt;

    logic [3:0] mt1, mu1, st1, su1;
    logic       fv1, ge1, ae1, stl1;
    logic [3:0] mt3, mu3, st3, su3;
    logic       fv3, ge3, ae3, stl3;
    logic [3:0] mtt, mut, stt, sut;
    logic       fvt, get, aet, stlt;

    seg_scan_decoder #(.SETTLE_CYCLES(1), .TIMEOUT_CYCLES(1024)) u_dut1 (
        .clk(clk), .reset(reset), .anode(an1), .segments(sg1),
        .minutes_tens(mt1), .minutes_units(mu1), .seconds_tens(st1), .seconds_units(su1),
        .frame_valid(fv1), .glyph_error(ge1), .anode_error(ae1), .stale(stl1)
    );

    seg_scan_decoder #(.SETTLE_CYCLES(3), .TIMEOUT_CYCLES(1024)) u_dut3 (
        .clk(clk), .reset(reset), .anode(an3), .segments(sg3),
        .minutes_tens(mt3), .minutes_units(mu3), .seconds_tens(st3), .seconds_units(su3),
        .frame_valid(fv3), .glyph_error(ge3), .anode_error(ae3), .stale(stl3)
    );

    seg_scan_decoder #(.SETTLE_CYCLES(1), .TIMEOUT_CYCLES(16)) u_dutt (
        .clk(clk), .reset(reset), .anode(ant), .segments(sgt),
        .minutes_tens(mtt), .minutes_units(mut), .seconds_tens(stt), .seconds_units(sut),
        .frame_valid(fvt), .glyph_error(get), .anode_error(aet), .stale(stlt)
    );

    // Active-low glyphs for digits 0..9.
    logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] BAD   = 7'b1010101;

    logic [15:0] exp1_q[$];
    logic [15:0] exp3_q[$];
    logic [15:0] expt_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int fv1_n, ge1_n, ae1_n, fv3_n, fvt_n;

    // ------------------------------------------------------------------------
    // Scoreboard monitors
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        logic [15:0] e;
        if (fv1) begin
            fv1_n++;
            n_cmp++;
            assert (exp1_q.size() != 0) else begin
                n_fail++;
                $error("FAIL frame1_unexpected: observed frame_valid=1 required 0");
            end
            if (exp1_q.size() != 0) begin
                e = exp1_q.pop_front();
                n_cmp++;
                assert ({mt1, mu1, st1, su1} === e) else begin
                    n_fail++;
                    $error("FAIL frame1: observed %h required %h", {mt1, mu1, st1, su1}, e);
                end
            end
        end
        if (ge1) ge1_n++;
        if (ae1) ae1_n++;
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (fv3) begin
            fv3_n++;
            n_cmp++;
            assert (exp3_q.size() != 0) else begin
                n_fail++;
                $error("FAIL frame3_unexpected: observed frame_valid=1 required 0");
            end
            if (exp3_q.size() != 0) begin
                e = exp3_q.pop_front();
                n_cmp++;
                assert ({mt3, mu3, st3, su3} === e) else begin
                    n_fail++;
                    $error("FAIL frame3: observed %h required %h", {mt3, mu3, st3, su3}, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (fvt) begin
            fvt_n++;
            n_cmp++;
            assert (expt_q.size() != 0) else begin
                n_fail++;
                $error("FAIL framet_unexpected: observed frame_valid=1 required 0");
            end
            if (expt_q.size() != 0) begin
                e = expt_q.pop_front();
                n_cmp++;
                assert ({mtt, mut, stt, sut} === e) else begin
                    n_fail++;
                    $error("FAIL framet: observed %h required %h", {mtt, mut, stt, sut}, e);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver and check tasks
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input int sel, input logic [3:0] a, input logic [6:0] s, input int n);
        case (sel)
            1:       begin an1 = a; sg1 = s; end
            3:       begin an3 = a; sg3 = s; end
            default: begin ant = a; sgt = s; end
        endcase
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives positions 0..3 in order with the given segments, then idles.
    task automatic scan(input int sel, input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3, input int hold);
        drive(sel, 4'b1110, s0, hold);
        drive(sel, 4'b1101, s1, hold);
        drive(sel, 4'b1011, s2, hold);
        drive(sel, 4'b0111, s3, hold);
        drive(sel, 4'b1111, BLANK, 4);
    endtask

    task automatic clr_counts();
        fv1_n = 0; ge1_n = 0; ae1_n = 0; fv3_n = 0; fvt_n = 0;
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        clr_counts();
        reset = 1'b1;
        an1 = 4'hF; an3 = 4'hF; ant = 4'hF;
        sg1 = BLANK; sg3 = BLANK; sgt = BLANK;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("rst_digits1", {mt1, mu1, st1, su1}, 16'h0000);
        check("rst_flags1", {fv1, ge1, ae1, stl1}, 4'b0000);
        check("rst_digits3", {mt3, mu3, st3, su3}, 16'h0000);
        check("rst_flagst", {fvt, get, aet, stlt}, 4'b0000);
        reset = 1'b0;
        drive(1, 4'hF, BLANK, 2);

        // Basic scan of glyphs 5,4,3,2 on positions 0..3.
        clr_counts();
        exp1_q.push_back(16'h2345);
        scan(1, glyph[5], glyph[4], glyph[3], glyph[2], 1);
        check("scan_fv", fv1_n, 1);
        check("scan_ge", ge1_n, 0);
        check("scan_ae", ae1_n, 0);
        check("scan_digits", {mt1, mu1, st1, su1}, 16'h2345);

        // Two anodes low held for three cycles gives one error and no capture.
        clr_counts();
        drive(1, 4'b1100, glyph[1], 3);
        drive(1, 4'b1111, BLANK, 3);
        check("multi_ae", ae1_n, 1);
        check("multi_fv", fv1_n, 0);
        check("multi_digits", {mt1, mu1, st1, su1}, 16'h2345);

        // An unrecognised glyph on position 0 decodes to F.
        clr_counts();
        exp1_q.push_back(16'h321F);
        scan(1, BAD, glyph[1], glyph[2], glyph[3], 1);
        check("bad_ge", ge1_n, 1);
        check("bad_fv", fv1_n, 1);
        check("bad_digits", {mt1, mu1, st1, su1}, 16'h321F);

        // A blank digit decodes to A and raises no error.
        clr_counts();
        exp1_q.push_back(16'h0A87);
        scan(1, glyph[7], glyph[8], BLANK, glyph[0], 1);
        check("blank_ge", ge1_n, 0);
        check("blank_digits", {mt1, mu1, st1, su1}, 16'h0A87);

        // A repeated position overwrites its earlier digit.
        clr_counts();
        drive(1, 4'b1110, glyph[1], 1);
        exp1_q.push_back(16'h4906);
        scan(1, glyph[6], glyph[0], glyph[9], glyph[4], 1);
        check("ovr_fv", fv1_n, 1);
        check("ovr_ge", ge1_n, 0);

        // Reset after two captures discards the partial frame.
        clr_counts();
        drive(1, 4'b1110, glyph[9], 1);
        drive(1, 4'b1101, glyph[5], 1);
        drive(1, 4'b1111, BLANK, 2);
        reset = 1'b1;
        drive(1, 4'b1111, BLANK, 2);
        check("mid_rst_digits", {mt1, mu1, st1, su1}, 16'h0000);
        reset = 1'b0;
        drive(1, 4'b1111, BLANK, 2);
        drive(1, 4'b1011, glyph[5], 1);
        drive(1, 4'b0111, glyph[9], 1);
        drive(1, 4'b1111, BLANK, 3);
        check("post_rst_partial_fv", fv1_n, 0);
        exp1_q.push_back(16'h9599);
        drive(1, 4'b1110, glyph[9], 1);
        drive(1, 4'b1101, glyph[9], 1);
        drive(1, 4'b1111, BLANK, 4);
        check("post_rst_fv", fv1_n, 1);
        check("post_rst_digits", {mt1, mu1, st1, su1}, 16'h9599);

        // SETTLE_CYCLES=3: holds of 2 cycles never qualify, holds of 3 do.
        clr_counts();
        scan(3, glyph[1], glyph[2], glyph[3], glyph[4], 2);
        check("settle2_fv", fv3_n, 0);
        exp3_q.push_back(16'h4321);
        scan(3, glyph[1], glyph[2], glyph[3], glyph[4], 3);
        check("settle3_fv", fv3_n, 1);
        check("settle3_digits", {mt3, mu3, st3, su3}, 16'h4321);

        // Stale-frame instance: a full scan is needed in both builds.
        clr_counts();
        expt_q.push_back(16'h4321);
        scan(2, glyph[1], glyph[2], glyph[3], glyph[4], 1);
        check("t_fv", fvt_n, 1);
        check("t_stale_after_frame", stlt, 1'b0);
`ifdef SEG_SCAN_TIMEOUT_EN
        drive(2, 4'b1110, glyph[7], 1);
        drive(2, 4'b1101, glyph[7], 1);
        drive(2, 4'b1111, BLANK, 20);
        check("t_stale_set", stlt, 1'b1);
        // The mask was cleared, so positions 2 and 3 alone cannot complete.
        drive(2, 4'b1011, glyph[5], 1);
        drive(2, 4'b0111, glyph[5], 1);
        drive(2, 4'b1111, BLANK, 3);
        check("t_mask_cleared_fv", fvt_n, 1);
        check("t_hold_digits", {mtt, mut, stt, sut}, 16'h4321);
        expt_q.push_back(16'h9876);
        scan(2, glyph[6], glyph[7], glyph[8], glyph[9], 1);
        check("t_refresh_fv", fvt_n, 2);
        check("t_stale_cleared", stlt, 1'b0);
`else
        drive(2, 4'b1111, BLANK, 20);
        check("t_stale_tied", stlt, 1'b0);
`endif

        check("exp1_drained", exp1_q.size(), 0);
        check("exp3_drained", exp3_q.size(), 0);
        check("expt_drained", expt_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
